// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: releases video then game reset then ready; a debounced button replays the sequence.
// Optional RESET_COUNT_EN adds a saturating 8-bit restart_count of accepted soft restarts.
module reset_release_sequencer #(
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 8,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       system_clock_buffered,
  input  logic       reset,
  input  logic       button_reset,
  output logic       video_reset,
  output logic       game_reset,
  output logic       ready
`ifdef RESET_COUNT_EN
  ,
  output logic [7:0] restart_count
`endif
);
  localparam int MAXC = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic [1:0] {HOLD, VIDEO_UP, GAME_UP, RUN} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            sync1_q, sync2_q, armed_q;
  logic [DW-1:0]   deb_q, deb_d;
  logic            deb_top, soft_req;
  assign deb_top  = deb_q == DW'(DEBOUNCE_CYCLES - 1);
  assign soft_req = sync2_q & deb_top & armed_q;
  assign deb_d    = !sync2_q ? '0 : deb_top ? deb_q : deb_q + 1'b1;
  // armed only re-arms on a synchronized low, so a held button yields one request
  always_ff @(posedge system_clock_buffered) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= button_reset;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      armed_q <= !sync2_q | (armed_q & !soft_req);
    end
  end
  always_ff @(posedge system_clock_buffered) begin
    if (reset || soft_req) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      video_reset <= 1'b1;
      game_reset  <= 1'b1;
      ready       <= 1'b0;
    end else begin
      video_reset <= state_q == HOLD;
      game_reset  <= state_q == HOLD || state_q == VIDEO_UP;
      ready       <= state_q == RUN;
      case (state_q)
        HOLD: begin
          state_q <= cnt_q == CW'(HOLD_CYCLES - 1) ? VIDEO_UP : HOLD;
          cnt_q   <= cnt_q == CW'(HOLD_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        end
        VIDEO_UP: begin
          state_q <= cnt_q == CW'(STAGE_GAP - 1) ? GAME_UP : VIDEO_UP;
          cnt_q   <= cnt_q == CW'(STAGE_GAP - 1) ? '0 : cnt_q + 1'b1;
        end
        GAME_UP: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end
`ifdef RESET_COUNT_EN
  always_ff @(posedge system_clock_buffered) begin
    if (reset) restart_count <= '0;
    else if (soft_req && restart_count != 8'hff) restart_count <= restart_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb_reset_release_sequencer: random and directed stimulus against a cycles-since-restart reference model.
module tb_reset_release_sequencer;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int DEB  = 4;
  logic clk = 1'b0;
  logic reset, button_reset;
  logic video_reset, game_reset, ready;
  logic [7:0] restart_count;
  int checks = 0;
  int errors = 0;
  int t, run, rc;
  bit armed_ok, p0, p1, lvl;
  always #5 clk = ~clk;
  reset_release_sequencer #(.HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .DEBOUNCE_CYCLES(DEB)) dut (
    .system_clock_buffered(clk),
    .reset(reset),
    .button_reset(button_reset),
    .video_reset(video_reset),
    .game_reset(game_reset),
    .ready(ready)
`ifdef RESET_COUNT_EN
    ,
    .restart_count(restart_count)
`endif
  );
`ifndef RESET_COUNT_EN
  assign restart_count = 8'd0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask
  // t counts edges since the last restart origin (reset edge or accepted press)
  task automatic step();
    @(posedge clk);
    if (reset) begin
      t = 0; run = 0; rc = 0; armed_ok = 0; p0 = 0; p1 = 0;
    end else begin
      lvl = p1; p1 = p0; p0 = button_reset;
      if (lvl) run++;
      else begin
        run = 0;
        armed_ok = 1;
      end
      if (lvl && run == DEB && armed_ok) begin
        t = 0;
        rc = rc < 255 ? rc + 1 : 255;
      end else if (t < 100000) t++;
    end
    #1;
    check("video_reset", video_reset, t <= HOLD);
    check("game_reset", game_reset, t <= HOLD + GAP);
    check("ready", ready, t >= HOLD + GAP + 2);
`ifdef RESET_COUNT_EN
    check("restart_count", restart_count, rc);
`endif
    @(negedge clk);
  endtask
  task automatic steps(input int n);
    repeat (n) step();
  endtask
  task automatic press(input int hi, input int lo);
    button_reset = 1'b1;
    steps(hi);
    button_reset = 1'b0;
    steps(lo);
  endtask
  initial begin
    reset = 1'b1;
    button_reset = 1'b0;
    t = 0; run = 0; rc = 0; armed_ok = 0; p0 = 0; p1 = 0; lvl = 0;
    @(negedge clk);
    steps(5);
    reset = 1'b0;
    steps(30);
    for (int i = 0; i < 5; i++) begin
      button_reset = (i % 2) == 0;
      step();
    end
    button_reset = 1'b0;
    steps(10);
    press(20, 40);
    press(6, 5);
    press(6, 40);
    press(6, 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(30);
    button_reset = 1'b1;
    steps(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(10);
    button_reset = 1'b0;
    steps(30);
    for (int i = 0; i < 60; i++) begin
      button_reset = $urandom_range(0, 1);
      reset = $urandom_range(0, 29) == 0;
      steps($urandom_range(1, 8));
    end
    reset = 1'b0;
    button_reset = 1'b0;
    steps(30);
    for (int i = 0; i < 260; i++) press(5, 3);
    steps(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
